// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
// Provides the controller state encoding, address/data widths, the byte
// offset of an 8-byte word, and a helper that word-aligns a byte address.
package dcache_pkg;

    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned DATA_W      = 64;
    // Bits [2:0] of a byte address select a byte inside the 64-bit word.
    localparam int unsigned WORD_OFFSET = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill,
        StWthru,
        StResp
    } state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & {{(ADDR_W - WORD_OFFSET){1'b1}}, {WORD_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Bundles the core-side request/response signals and the backing-memory
// handshake of the data cache.
//   master : environment side (core + backing memory model)
//   slave  : the cache itself
// Core side   : dcache_en, dcache_wren, dcache_addr, dcache_wdata -> cache;
//               dcache_rdata, dcache_done <- cache
// Memory side : mem_req, mem_wren, mem_addr, mem_wdata <- cache;
//               mem_rdata, mem_ack -> cache
interface dcache_if;
    import dcache_pkg::*;

    logic              dcache_en;
    logic              dcache_wren;
    logic [ADDR_W-1:0] dcache_addr;
    logic [DATA_W-1:0] dcache_wdata;
    logic [DATA_W-1:0] dcache_rdata;
    logic              dcache_done;

    logic              mem_req;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output dcache_en, dcache_wren, dcache_addr, dcache_wdata, mem_rdata, mem_ack,
        input  dcache_rdata, dcache_done, mem_req, mem_wren, mem_addr, mem_wdata
    );

    modport slave (
        input  dcache_en, dcache_wren, dcache_addr, dcache_wdata, mem_rdata, mem_ack,
        output dcache_rdata, dcache_done, mem_req, mem_wren, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// One asynchronous read port (rd_*) and one synchronous write port (wr_*).
// A write always marks the set valid. Only the valid bits are reset; tag and
// data contents are meaningless while their valid bit is clear.
//   clk, reset        : clock, asynchronous active-high reset
//   rd_idx            : set index to read
//   rd_valid/tag/data : contents of that set
//   wr_en/idx/tag/data: write a full entry into a set
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned SETS  = 64,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = ADDR_W - WORD_OFFSET - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one
// 64-bit word per set and a single outstanding request.
//   clk   : sole clock
//   reset : asynchronous active-high reset; abandons any transaction
//   bus   : dcache_if slave modport carrying the core request/response
//           signals and the backing-memory handshake
// Every output on the bus is a register, so no input reaches mem_req or
// dcache_done combinationally.
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned SETS = 64
) (
    input  logic    clk,
    input  logic    reset,
    dcache_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - WORD_OFFSET - IDX_W;

    state_t            state_q;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              mem_req_q;
    logic              mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;

    assign idx = addr_q[WORD_OFFSET +: IDX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];
    assign hit = rd_valid && (rd_tag == tag);

    // Array updates: a write hit refreshes the word in LOOKUP (tag unchanged),
    // a fill installs the returned word. Both are gated by state, which reset
    // forces to idle, so a reset never lands a partial update.
    always_comb begin
        arr_we    = 1'b0;
        arr_wdata = wdata_q;
        if (state_q == StLookup && wren_q && hit) begin
            arr_we    = 1'b1;
            arr_wdata = wdata_q;
        end else if (state_q == StFill && bus.mem_ack) begin
            arr_we    = 1'b1;
            arr_wdata = bus.mem_rdata;
        end
    end

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_we),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.dcache_en) begin
                        wren_q  <= bus.dcache_wren;
                        addr_q  <= bus.dcache_addr;
                        wdata_q <= bus.dcache_wdata;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (wren_q) begin
                        // Every store goes to memory, hit or miss.
                        mem_req_q   <= 1'b1;
                        mem_wren_q  <= 1'b1;
                        mem_addr_q  <= word_align(addr_q);
                        mem_wdata_q <= wdata_q;
                        state_q     <= StWthru;
                    end else if (hit) begin
                        rdata_q <= rd_data;
                        done_q  <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_wren_q <= 1'b0;
                        mem_addr_q <= word_align(addr_q);
                        state_q    <= StFill;
                    end
                end
                StFill: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= bus.mem_rdata;
                        done_q    <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StWthru: begin
                    if (bus.mem_ack) begin
                        mem_req_q  <= 1'b0;
                        mem_wren_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign bus.dcache_rdata = rdata_q;
    assign bus.dcache_done  = done_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_wren     = mem_wren_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule
